// File: rtl/baudot_tx_sched.sv
// Baudot (ITA2) transmit scheduler: LTRS/FIGS shift insertion plus async 5-bit framing.
// Build option BAUDOT_USOS_EN: a completed space (0x04) frame returns the shift state to LTRS.
module baudot_tx_sched #(
  parameter int unsigned CLOCK_RATE  = 1000,
  parameter int unsigned BAUD_X100   = 4545,
  parameter int unsigned STOP_HALVES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [4:0] sym_code,
  input  logic [1:0] sym_class,
  output logic       sym_ready,
  output logic       baudot_out,
  output logic       busy,
  output logic [1:0] shift_state
);

  localparam int unsigned BIT_CYCLES  = (CLOCK_RATE * 100) / BAUD_X100;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned STOP_CYCLES = STOP_HALVES * HALF_CYCLES;
  localparam int unsigned MAX_CYCLES  = (BIT_CYCLES > STOP_CYCLES) ? BIT_CYCLES : STOP_CYCLES;
  localparam int unsigned CNT_W       = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_CYCLES - 1);

  localparam logic [4:0] LTRS_CODE  = 5'h1F;
  localparam logic [4:0] FIGS_CODE  = 5'h1B;
  localparam logic [4:0] SPACE_CODE = 5'h04;

  localparam logic [1:0] CLS_LETTERS = 2'b01;
  localparam logic [1:0] CLS_FIGURES = 2'b10;
  localparam logic [1:0] CLS_RAW     = 2'b11;

  localparam logic [1:0] SH_UNKNOWN = 2'b00;
  localparam logic [1:0] SH_LTRS    = 2'b01;
  localparam logic [1:0] SH_FIGS    = 2'b10;

`ifdef BAUDOT_USOS_EN
  localparam bit USOS_EN = 1'b1;
`else
  localparam bit USOS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [4:0]       tx_code;
  logic [4:0]       pend_code;
  logic             pend_valid;

  // One counter times every line element; it reloads at each boundary instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      tx_code     <= 5'd0;
      pend_code   <= 5'd0;
      pend_valid  <= 1'b0;
      sym_ready   <= 1'b0;
      baudot_out  <= 1'b1;
      busy        <= 1'b0;
      shift_state <= SH_UNKNOWN;
    end else begin
      case (state)
        IDLE: begin
          baudot_out <= 1'b1;
          if (sym_valid && sym_ready) begin
            state      <= START;
            baudot_out <= 1'b0;
            sym_ready  <= 1'b0;
            busy       <= 1'b1;
            cnt        <= BIT_LOAD;
            bit_idx    <= 3'd0;
            tx_code    <= sym_code;
            // A needed shift goes out first; the symbol itself waits in pending.
            case (sym_class)
              CLS_LETTERS: begin
                if (shift_state != SH_LTRS) begin
                  tx_code     <= LTRS_CODE;
                  pend_code   <= sym_code;
                  pend_valid  <= 1'b1;
                  shift_state <= SH_LTRS;
                end
              end
              CLS_FIGURES: begin
                if (shift_state != SH_FIGS) begin
                  tx_code     <= FIGS_CODE;
                  pend_code   <= sym_code;
                  pend_valid  <= 1'b1;
                  shift_state <= SH_FIGS;
                end
              end
              CLS_RAW: begin
                if (sym_code == LTRS_CODE) begin
                  shift_state <= SH_LTRS;
                end else if (sym_code == FIGS_CODE) begin
                  shift_state <= SH_FIGS;
                end
              end
              default: ;
            endcase
          end else begin
            sym_ready <= !pend_valid;
            busy      <= pend_valid;
          end
        end

        START: begin
          if (cnt == '0) begin
            state      <= DATA;
            baudot_out <= tx_code[0];
            cnt        <= BIT_LOAD;
            bit_idx    <= 3'd0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == '0) begin
            if (bit_idx == 3'd4) begin
              state      <= STOP;
              baudot_out <= 1'b1;
              cnt        <= STOP_LOAD;
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              baudot_out <= tx_code[bit_idx + 3'd1];
              cnt        <= BIT_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == '0) begin
            if (USOS_EN && (tx_code == SPACE_CODE)) begin
              shift_state <= SH_LTRS;
            end
            if (pend_valid) begin
              state      <= START;
              tx_code    <= pend_code;
              pend_valid <= 1'b0;
              baudot_out <= 1'b0;
              cnt        <= BIT_LOAD;
              bit_idx    <= 3'd0;
            end else begin
              state     <= IDLE;
              sym_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/baudot_tx_sched.md
Name: baudot_tx_sched

Overview:
- Transmit-side controller for the Baudot (ITA2) serial link.
- Accepts 5-bit Baudot symbols, each tagged with its shift class, from an upstream requester over a valid/ready handshake.
- Tracks the far-end LTRS/FIGS shift state and inserts a LTRS (0x1F) or FIGS (0x1B) code only when the state must change.
- Serialises every code as a 5-bit async frame with start and stop bits on baudot_out, at the Baudot rate derived from the tile clock.

Parameters:
- CLOCK_RATE, 1000, tile clock frequency in Hz.
- BAUD_X100, 4545, line rate ×100 (45.45 Bd).
- STOP_HALVES, 3, stop length in half-bit units (3 = 1.5 stop bits).
- Derived: BIT_CYCLES = floor(CLOCK_RATE*100/BAUD_X100), = 22 at defaults.
- Derived: HALF_CYCLES = BIT_CYCLES/2 (floor), = 11.

Ports:
- clk  input  1  tile clock.
- rst_n  input  1  asynchronous active-low reset.
- sym_valid  input  1  requester has a symbol.
- sym_code  input  5  ITA2 code.
- sym_class  input  2  00 neutral, 01 letters, 10 figures, 11 raw.
- sym_ready  output  1  block can accept a symbol this cycle.
- baudot_out  output  1  serial line; mark = 1.
- busy  output  1  frame in progress or symbol pending.
- shift_state  output  2  00 unknown, 01 LTRS, 10 FIGS.

Behaviour:
- Reset (async, rst_n=0):
  - baudot_out=1, sym_ready=0, busy=0, shift_state=00.
  - FSM=IDLE, pending register cleared.
  - Any frame in flight is truncated immediately; line returns to mark.
  - sym_ready rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: baudot_out=1. sym_ready=1 iff pending empty; busy=0 only here with pending empty.
  - Accept occurs when sym_valid & sym_ready at a clk edge. sym_code and sym_class are captured; the requester may change them afterwards.
- Shift decision at accept:
  - letters with shift_state≠LTRS: transmit 0x1F first, hold the symbol in pending, set shift_state=LTRS when the 0x1F frame starts.
  - figures with shift_state≠FIGS: transmit 0x1B first, hold the symbol in pending, set shift_state=FIGS when the 0x1B frame starts.
  - neutral: no shift inserted; shift_state unchanged. Neutral codes: 0x00 NUL, 0x02 LF, 0x04 SP, 0x08 CR.
  - raw: sent as-is with no insertion. If the code is 0x1F or 0x1B, shift_state updates to LTRS/FIGS at frame start.
- Frame timing:
  - START is entered the cycle after accept.
  - START: line 0 for BIT_CYCLES.
  - DATA: 5 bits, LSB first, BIT_CYCLES each.
  - STOP: line 1 for STOP_HALVES*HALF_CYCLES.
  - At defaults a frame is 22+110+33 = 165 cycles.
- After STOP:
  - If pending is valid, go directly to START for the pending symbol with no idle cycle, and clear pending.
  - Otherwise go to IDLE.
- Throughput:
  - Back-to-back accepts are spaced 166 cycles: 165 frame cycles plus the IDLE accept cycle.
  - A shift-inserted pair occupies 330 cycles from the first START.
- sym_ready=0 in START, DATA and STOP. No accept is possible mid-frame.
- A single bit/duration counter, sized for max(BIT_CYCLES, STOP_HALVES*HALF_CYCLES), reloads on every bit boundary; it has no free-running wrap.
- A bit index counts 0..4 and never wraps past 4.

Optional Feature:
- Macro BAUDOT_USOS_EN (unshift-on-space).
- Defined: when the frame of code 0x04 (any class) completes STOP, shift_state is forced to LTRS, matching receivers that drop to letters on space. A following figures symbol therefore gets a FIGS insertion.
- Undefined: space leaves shift_state unchanged.

Test Plan:
- Reset, then one letters symbol 0x03 ('A'): LTRS frame 0,1,1,1,1,1,stop, then A frame 0,1,1,0,0,0,stop. Each bit is 22 cycles and each stop 33 cycles. The A frame START follows the LTRS stop with no gap. shift_state=01. sym_ready low for 330 cycles.
- After that, letters 0x03 again: a single 165-cycle frame with no insertion; sym_ready returns to 1 on the cycle after STOP.
- Figures 0x17 ('1'), then letters 0x03: FIGS, 0x17, LTRS, 0x03 frames, with shift_state 10 then 01.
- Neutral 0x04 in shift_state FIGS, then figures 0x17:
  - Without BAUDOT_USOS_EN: frames are 0x04 then 0x17.
  - With BAUDOT_USOS_EN: frames are 0x04, FIGS, 0x17.
- rst_n pulsed low in DATA bit 2 of a frame with a symbol pending:
  - Same cycle: baudot_out=1, shift_state=00.
  - The pending symbol is never transmitted.
  - The next letters symbol gets LTRS inserted.
- Raw 0x1B from shift_state unknown: one frame; shift_state becomes 10 at START. A following figures symbol is not preceded by an inserted shift.
